// File: rtl/proc_pkg.sv
// Shared types and constants for the multi-cycle control sequencer.
// Optional feature macro: PROC_CTRL_SUB_EN (enables the sub opcode).
package proc_pkg;

    localparam int IR_W  = 9;
    localparam int OP_HI = 8;
    localparam int OP_LO = 6;
    localparam int X_HI  = 5;
    localparam int X_LO  = 3;
    localparam int Y_HI  = 2;
    localparam int Y_LO  = 0;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    localparam logic [1:0] BUS_REG = 2'b00;
    localparam logic [1:0] BUS_DIN = 2'b01;
    localparam logic [1:0] BUS_G   = 2'b10;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        C_MV  = 3'd0,
        C_MVI = 3'd1,
        C_ADD = 3'd2,
        C_SUB = 3'd3,
        C_ILL = 3'd4
    } op_cls_e;

endpackage

// File: rtl/proc_control_fsm_if.sv
// Sequencer-side bundle: Run/DIN in, datapath controls and status out.
// master = sequencer, slave = datapath / instruction source.
interface proc_control_fsm_if #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
);
    logic              Run;
    logic [DATA_W-1:0] DIN;
    logic [2:0]        Sel;
    logic [1:0]        BusSrc;
    logic [NREG-1:0]   RIn;
    logic              AIn;
    logic              GIn;
    logic              AddSub;
    logic              IRIn;
    logic              Done;
    logic [DATA_W-1:0] InstrCount;

    modport master (
        input  Run, DIN,
        output Sel, BusSrc, RIn, AIn, GIn, AddSub, IRIn, Done, InstrCount
    );

    modport slave (
        output Run, DIN,
        input  Sel, BusSrc, RIn, AIn, GIn, AddSub, IRIn, Done, InstrCount
    );
endinterface

// File: rtl/proc_ir_decode.sv
// Combinational IR decode: opcode class, X one-hot/index, Y index.
// PROC_CTRL_SUB_EN selects whether opcode 011 decodes as sub or illegal.
module proc_ir_decode
    import proc_pkg::*;
#(
    parameter int NREG = 8
) (
    input  logic [IR_W-1:0] ir_i,
    output op_cls_e         cls_o,
    output logic [NREG-1:0] x_oh_o,
    output logic [2:0]      x_o,
    output logic [2:0]      y_o
);

    assign x_o    = ir_i[X_HI:X_LO];
    assign y_o    = ir_i[Y_HI:Y_LO];
    assign x_oh_o = NREG'(1) << x_o;

    always_comb begin
        cls_o = C_ILL;
        unique case (ir_i[OP_HI:OP_LO])
            OP_MV:   cls_o = C_MV;
            OP_MVI:  cls_o = C_MVI;
            OP_ADD:  cls_o = C_ADD;
`ifdef PROC_CTRL_SUB_EN
            OP_SUB:  cls_o = C_SUB;
`endif
            default: cls_o = C_ILL;
        endcase
    end

endmodule

// File: rtl/proc_control_fsm.sv
// T0..T3 control sequencer driving register mux, bus source and load enables.
// Optional feature macro: PROC_CTRL_SUB_EN (sub opcode, AddSub output).
module proc_control_fsm
    import proc_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input  logic                Clock,
    input  logic                Resetn,
    proc_control_fsm_if.master  bus
);

    state_e            state_q, state_d;
    logic [IR_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0] cnt_q, cnt_d;

    op_cls_e           cls;
    logic [NREG-1:0]   x_oh;
    logic [2:0]        x_idx;
    logic [2:0]        y_idx;

    logic [2:0]        sel;
    logic [1:0]        bus_src;
    logic [NREG-1:0]   rin;
    logic              ain;
    logic              gin;
    logic              add_sub;
    logic              irin;
    logic              done;
    logic              unused_din;

    proc_ir_decode #(.NREG(NREG)) u_dec (
        .ir_i   (ir_q),
        .cls_o  (cls),
        .x_oh_o (x_oh),
        .x_o    (x_idx),
        .y_o    (y_idx)
    );

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= T0;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        sel     = '0;
        bus_src = BUS_REG;
        rin     = '0;
        ain     = 1'b0;
        gin     = 1'b0;
        add_sub = 1'b0;
        irin    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            T0: begin
                irin = bus.Run;
                if (bus.Run) begin
                    ir_d    = bus.DIN[IR_W-1:0];
                    state_d = T1;
                end
            end
            T1: begin
                state_d = T0;
                unique case (cls)
                    C_MV: begin
                        sel  = y_idx;
                        rin  = x_oh;
                        done = 1'b1;
                    end
                    C_MVI: begin
                        bus_src = BUS_DIN;
                        rin     = x_oh;
                        done    = 1'b1;
                    end
                    C_ADD, C_SUB: begin
                        sel     = x_idx;
                        ain     = 1'b1;
                        state_d = T2;
                    end
                    default: done = 1'b1;
                endcase
            end
            T2: begin
                state_d = T0;
                if (cls == C_ADD || cls == C_SUB) begin
                    sel     = y_idx;
                    gin     = 1'b1;
`ifdef PROC_CTRL_SUB_EN
                    add_sub = (cls == C_SUB);
`endif
                    state_d = T3;
                end
            end
            T3: begin
                bus_src = BUS_G;
                rin     = x_oh;
                done    = 1'b1;
                state_d = T0;
            end
            default: state_d = T0;
        endcase
    end

    assign cnt_d = done ? cnt_q + DATA_W'(1) : cnt_q;

    // Upper DIN bits belong to the datapath (immediates), not to the IR.
    assign unused_din = ^bus.DIN[DATA_W-1:IR_W];

    assign bus.Sel        = sel;
    assign bus.BusSrc     = bus_src;
    assign bus.RIn        = rin;
    assign bus.AIn        = ain;
    assign bus.GIn        = gin;
    assign bus.AddSub     = add_sub;
    assign bus.IRIn       = irin & Resetn;
    assign bus.Done       = done;
    assign bus.InstrCount = cnt_q;

endmodule
